ram_line_fifo: RTL and testbench
================================

RAM_LINE_FIFO -- requirements
Module: ram_line_fifo

Interface
REQ-001 Parameters, one per line: DATA_WIDTH, 24, pixel width; ADDRESS_WIDTH, 11, per-line RAM address width; LINE_NUM, 4, line buffers in ring (fixed 4 for fifoNum encoding).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset; asynchronous assert, active-low.
REQ-004 ramWrtEn  in  1  write strobe from input control stage.
REQ-005 ramWrtAddr  in  ADDRESS_WIDTH  write address within current write line.
REQ-006 dataIn  in  DATA_WIDTH  write pixel.
REQ-007 jmp  in  1  one-cycle pulse; commit current write line, advance write pointer.
REQ-008 rdAddr  in  ADDRESS_WIDTH  read address, applied to both read lines.
REQ-009 rdJmp  in  1  one-cycle pulse; release oldest stored line.
REQ-010 fifoNum  out  3  committed lines held, 0..4.
REQ-011 rdValid  out  1  high when fifoNum >= 2.
REQ-012 rdData0  out  DATA_WIDTH  pixel at rdAddr in oldest line.
REQ-013 rdData1  out  DATA_WIDTH  pixel at rdAddr in second-oldest line.

Function
REQ-014 Four line RAMs; 2-bit write pointer wp, 2-bit read pointer rp, both wrap 3->0.
REQ-015 ramWrtEn=1 with fifoNum<4: write dataIn to RAM[wp] at ramWrtAddr same edge.
REQ-016 ramWrtEn=1 with fifoNum==4: write dropped, no RAM changes.
REQ-017 jmp=1 with fifoNum<4: wp<=wp+1, fifoNum increments next cycle.
REQ-018 jmp=1 with fifoNum==4: ignored, wp and fifoNum unchanged.
REQ-019 rdJmp=1 with fifoNum>0: rp<=rp+1, fifoNum decrements next cycle.
REQ-020 rdJmp=1 with fifoNum==0: ignored.
REQ-021 Simultaneous jmp and rdJmp, both legal: both pointers advance, fifoNum unchanged; at fifoNum==4 rdJmp is taken first so jmp is also accepted; at fifoNum==0 rdJmp ignored, jmp accepted.
REQ-022 Read latency 1 cycle: rdData0/rdData1 registered from RAM[rp]/RAM[rp+1] at rdAddr sampled previous edge.
REQ-023 rdData0/rdData1 hold value when rdValid=0; content then undefined but stable.
REQ-024 A write to RAM[wp] never aliases RAM[rp] or RAM[rp+1] while they hold committed lines (guaranteed by REQ-016).
REQ-025 fifoNum, rdValid registered; update edge after the accepted jmp/rdJmp.

Reset
REQ-026 rst low: wp=0, rp=0, fifoNum=0, rdValid=0, rdData0=rdData1=0, immediately and asynchronously.
REQ-027 RAM contents not reset; reset mid-line discards all committed and partial lines.
REQ-028 Reset release synchronous to clk.

Configuration
REQ-029 Macro RAM_FIFO_OVF_DET_EN defined: add outputs ovfErr and udfErr (1 bit each, reset 0), sticky-set on jmp/ramWrtEn when full, resp. rdJmp when empty; cleared only by reset.
REQ-030 Macro undefined: ports ovfErr/udfErr absent, no detection logic; behaviour otherwise identical.

Structure
REQ-031 Shared package scaler_pkg holds DATA_WIDTH, ADDRESS_WIDTH, LINE_NUM defaults and the fifo-count width constant.
REQ-032 One sub-module line_ram: simple dual-port, 2^ADDRESS_WIDTH x DATA_WIDTH, synchronous write, registered read; instantiated LINE_NUM times.

Verification
REQ-033 Reset, write 640 pixels line 0, jmp -> fifoNum=1, rdValid=0.
REQ-034 Fill lines 0..3 with value = lineIdx*1000+addr, jmp each -> fifoNum=4; rdAddr=5 -> next cycle rdData0=5, rdData1=1005.
REQ-035 At fifoNum=4 write addr 7 value 0xFFFFFF and jmp -> dropped; fifoNum=4, line 0 addr 7 still reads 7; with macro ovfErr=1.
REQ-036 Same cycle jmp and rdJmp at fifoNum=4 -> fifoNum stays 4, rp=1, wp=1; at fifoNum=0 rdJmp alone -> fifoNum 0, udfErr=1 with macro.
REQ-037 Run 10 lines write/release to wrap pointers; rdData0 always equals oldest unreleased line pattern.
REQ-038 Assert rst low mid-line with fifoNum=3 -> same cycle fifoNum=0, rdValid=0, outputs 0; after release new line commits to RAM 0.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared constants for the scaler line-buffer blocks.
//   DATA_WIDTH_DEF    - default pixel width
//   ADDRESS_WIDTH_DEF - default per-line RAM address width
//   LINE_NUM_DEF      - line buffers in the ring (fixed at 4)
//   FIFO_CNT_W        - width of the committed-line count (0..4)
package scaler_pkg;

    localparam int DATA_WIDTH_DEF    = 24;
    localparam int ADDRESS_WIDTH_DEF = 11;
    localparam int LINE_NUM_DEF      = 4;
    localparam int FIFO_CNT_W        = 3;

    typedef logic [1:0] line_ptr_t;

endpackage

// File: rtl/ram_line_fifo_if.sv
// Handshake/data bundle for ram_line_fifo.
//   master: write side (ramWrtEn, ramWrtAddr, dataIn, jmp) and read side
//           controls (rdAddr, rdJmp); observes status and read data.
//   slave : the line FIFO itself; drives fifoNum, rdValid, rdData0/1.
// With RAM_FIFO_OVF_DET_EN defined, sticky ovfErr/udfErr flags are added.
interface ram_line_fifo_if
    import scaler_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
);
    logic                     ramWrtEn;
    logic [ADDRESS_WIDTH-1:0] ramWrtAddr;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic                     jmp;
    logic [ADDRESS_WIDTH-1:0] rdAddr;
    logic                     rdJmp;
    logic [FIFO_CNT_W-1:0]    fifoNum;
    logic                     rdValid;
    logic [DATA_WIDTH-1:0]    rdData0;
    logic [DATA_WIDTH-1:0]    rdData1;
`ifdef RAM_FIFO_OVF_DET_EN
    logic                     ovfErr;
    logic                     udfErr;
`endif

    modport master (
        output ramWrtEn, ramWrtAddr, dataIn, jmp, rdAddr, rdJmp,
`ifdef RAM_FIFO_OVF_DET_EN
        input  ovfErr, udfErr,
`endif
        input  fifoNum, rdValid, rdData0, rdData1
    );

    modport slave (
        input  ramWrtEn, ramWrtAddr, dataIn, jmp, rdAddr, rdJmp,
`ifdef RAM_FIFO_OVF_DET_EN
        output ovfErr, udfErr,
`endif
        output fifoNum, rdValid, rdData0, rdData1
    );

endinterface

// File: rtl/line_ram.sv
// Simple dual-port line RAM: 2^ADDRESS_WIDTH x DATA_WIDTH, synchronous
// write, registered read.
//   clk, rst_n       - clock, async active-low reset (read register only)
//   wr_en/waddr/wdata - write port
//   rd_en/raddr      - read port; rdata updates only when rd_en is high
//   rdata            - registered read data
module line_ram #(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Storage itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_line_fifo.sv
// Ring of four line RAMs used as a line FIFO. The writer fills the line at
// wp and commits it with jmp; the reader sees the two oldest committed lines
// (rp, rp+1) at a shared rdAddr with one cycle latency and releases the
// oldest with rdJmp.
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - ram_line_fifo_if slave modport (write/read controls, status, data)
// Optional: RAM_FIFO_OVF_DET_EN adds sticky ovfErr/udfErr outputs.
module ram_line_fifo
    import scaler_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int LINE_NUM      = LINE_NUM_DEF
) (
    input logic            clk,
    input logic            rst,
    ram_line_fifo_if.slave bus
);
    line_ptr_t             wp_q, wp_d, rp_q, rp_d, sel_q, sel_d, sel_nxt;
    logic [FIFO_CNT_W-1:0] fifo_num_q, fifo_num_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full, empty, rd_acc, jmp_acc, wr_acc;
    logic [DATA_WIDTH-1:0] ram_rdata [LINE_NUM];

    assign full    = (fifo_num_q == 3'd4);
    assign empty   = (fifo_num_q == 3'd0);
    assign rd_acc  = bus.rdJmp && !empty;
    // Release is evaluated first, so a commit at full is accepted when paired.
    assign jmp_acc = bus.jmp && (!full || rd_acc);
    assign wr_acc  = bus.ramWrtEn && !full;

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        fifo_num_d = fifo_num_q;
        if (jmp_acc) wp_d = wp_q + 2'd1;
        if (rd_acc)  rp_d = rp_q + 2'd1;
        fifo_num_d = fifo_num_q + {2'b00, jmp_acc} - {2'b00, rd_acc};
        rd_valid_d = (fifo_num_d >= 3'd2);
        // Read registers and their line select only move while valid, so the
        // outputs hold whenever rdValid is low.
        sel_d = rd_valid_q ? rp_q : sel_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            sel_q      <= '0;
            fifo_num_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            sel_q      <= sel_d;
            fifo_num_q <= fifo_num_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar i = 0; i < LINE_NUM; i++) begin : g_line
        line_ram #(
            .DATA_WIDTH   (DATA_WIDTH),
            .ADDRESS_WIDTH(ADDRESS_WIDTH)
        ) u_ram (
            .clk  (clk),
            .rst_n(rst),
            .wr_en(wr_acc && (wp_q == 2'(i))),
            .waddr(bus.ramWrtAddr),
            .wdata(bus.dataIn),
            .rd_en(rd_valid_q),
            .raddr(bus.rdAddr),
            .rdata(ram_rdata[i])
        );
    end

    assign sel_nxt     = sel_q + 2'd1;
    assign bus.rdData0 = ram_rdata[sel_q];
    assign bus.rdData1 = ram_rdata[sel_nxt];
    assign bus.fifoNum = fifo_num_q;
    assign bus.rdValid = rd_valid_q;

`ifdef RAM_FIFO_OVF_DET_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q || (full && (bus.ramWrtEn || (bus.jmp && !rd_acc)));
        udf_d = udf_q || (bus.rdJmp && empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.ovfErr = ovf_q;
    assign bus.udfErr = udf_q;
`endif

endmodule

// File: tb/tb_ram_line_fifo.sv
module tb_ram_line_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_line_fifo_if #(.DATA_WIDTH(24), .ADDRESS_WIDTH(11)) bus ();

    ram_line_fifo #(
        .DATA_WIDTH   (24),
        .ADDRESS_WIDTH(11),
        .LINE_NUM     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input int base, input int n);
        for (int a = 0; a < n; a++) begin
            bus.ramWrtEn   = 1'b1;
            bus.ramWrtAddr = 11'(a);
            bus.dataIn     = 24'(base + a);
            tick();
        end
        bus.ramWrtEn = 1'b0;
    endtask

    task automatic pulse_jmp();
        bus.jmp = 1'b1;
        tick();
        bus.jmp = 1'b0;
    endtask

    task automatic pulse_rdjmp();
        bus.rdJmp = 1'b1;
        tick();
        bus.rdJmp = 1'b0;
    endtask

    task automatic test_reset();
        bus.ramWrtEn = 1'b0; bus.ramWrtAddr = '0; bus.dataIn = '0;
        bus.jmp = 1'b0; bus.rdAddr = '0; bus.rdJmp = 1'b0;
        rst = 1'b0;
        tick(); tick();
        n_vec++; if (bus.fifoNum !== 3'd0) begin n_err++; $display("FAIL reset_fifoNum: got %0d want 0", bus.fifoNum); end
        n_vec++; if (bus.rdValid !== 1'b0) begin n_err++; $display("FAIL reset_rdValid: got %b want 0", bus.rdValid); end
        n_vec++; if (bus.rdData0 !== 24'd0 || bus.rdData1 !== 24'd0) begin n_err++; $display("FAIL reset_rdData: got %0d/%0d want 0/0", bus.rdData0, bus.rdData1); end
`ifdef RAM_FIFO_OVF_DET_EN
        n_vec++; if (bus.ovfErr !== 1'b0 || bus.udfErr !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b%b want 00", bus.ovfErr, bus.udfErr); end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_first_line();
        write_line(0, 640);
        pulse_jmp();
        n_vec++; if (bus.fifoNum !== 3'd1) begin n_err++; $display("FAIL first_fifoNum: got %0d want 1", bus.fifoNum); end
        n_vec++; if (bus.rdValid !== 1'b0) begin n_err++; $display("FAIL first_rdValid: got %b want 0", bus.rdValid); end
    endtask

    task automatic test_fill();
        for (int k = 1; k < 4; k++) begin
            write_line(k * 1000, 640);
            pulse_jmp();
        end
        n_vec++; if (bus.fifoNum !== 3'd4) begin n_err++; $display("FAIL fill_fifoNum: got %0d want 4", bus.fifoNum); end
        n_vec++; if (bus.rdValid !== 1'b1) begin n_err++; $display("FAIL fill_rdValid: got %b want 1", bus.rdValid); end
        bus.rdAddr = 11'd5;
        tick();
        n_vec++; if (bus.rdData0 !== 24'd5 || bus.rdData1 !== 24'd1005) begin n_err++; $display("FAIL fill_rd5: got %0d/%0d want 5/1005", bus.rdData0, bus.rdData1); end
        bus.rdAddr = 11'd639;
        tick();
        n_vec++; if (bus.rdData0 !== 24'd639 || bus.rdData1 !== 24'd1639) begin n_err++; $display("FAIL fill_rd639: got %0d/%0d want 639/1639", bus.rdData0, bus.rdData1); end
    endtask

    task automatic test_overflow();
        bus.ramWrtEn = 1'b1; bus.ramWrtAddr = 11'd7; bus.dataIn = 24'hFFFFFF; bus.jmp = 1'b1;
        tick();
        bus.ramWrtEn = 1'b0; bus.jmp = 1'b0;
        n_vec++; if (bus.fifoNum !== 3'd4) begin n_err++; $display("FAIL ovf_fifoNum: got %0d want 4", bus.fifoNum); end
        bus.rdAddr = 11'd7;
        tick();
        n_vec++; if (bus.rdData0 !== 24'd7) begin n_err++; $display("FAIL ovf_drop: got %0d want 7", bus.rdData0); end
`ifdef RAM_FIFO_OVF_DET_EN
        n_vec++; if (bus.ovfErr !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.ovfErr); end
`endif
    endtask

    task automatic test_simultaneous();
        bus.jmp = 1'b1; bus.rdJmp = 1'b1;
        tick();
        bus.jmp = 1'b0; bus.rdJmp = 1'b0;
        n_vec++; if (bus.fifoNum !== 3'd4) begin n_err++; $display("FAIL sim_fifoNum: got %0d want 4", bus.fifoNum); end
        bus.rdAddr = 11'd5;
        tick();
        n_vec++; if (bus.rdData0 !== 24'd1005 || bus.rdData1 !== 24'd2005) begin n_err++; $display("FAIL sim_rp1: got %0d/%0d want 1005/2005", bus.rdData0, bus.rdData1); end
        for (int k = 3; k >= 0; k--) begin
            pulse_rdjmp();
            n_vec++; if (bus.fifoNum !== 3'(k)) begin n_err++; $display("FAIL drain_fifoNum: got %0d want %0d", bus.fifoNum, k); end
        end
`ifdef RAM_FIFO_OVF_DET_EN
        n_vec++; if (bus.udfErr !== 1'b0) begin n_err++; $display("FAIL udf_pre: got %b want 0", bus.udfErr); end
`endif
        pulse_rdjmp();
        n_vec++; if (bus.fifoNum !== 3'd0 || bus.rdValid !== 1'b0) begin n_err++; $display("FAIL udf_state: got %0d/%b want 0/0", bus.fifoNum, bus.rdValid); end
`ifdef RAM_FIFO_OVF_DET_EN
        n_vec++; if (bus.udfErr !== 1'b1) begin n_err++; $display("FAIL udf_flag: got %b want 1", bus.udfErr); end
`endif
        // Last valid read selected RAM3/RAM0 at addr 5; outputs must hold.
        bus.rdAddr = 11'd9;
        tick(); tick();
        n_vec++; if (bus.rdData0 !== 24'd3005 || bus.rdData1 !== 24'd5) begin n_err++; $display("FAIL hold: got %0d/%0d want 3005/5", bus.rdData0, bus.rdData1); end
    endtask

    task automatic test_wrap();
        logic [23:0] e0, e1;
        write_line(10000, 16);
        pulse_jmp();
        for (int k = 1; k < 10; k++) begin
            write_line(10000 + k * 1000, 16);
            pulse_jmp();
            n_vec++; if (bus.fifoNum !== 3'd2) begin n_err++; $display("FAIL wrap_fifoNum%0d: got %0d want 2", k, bus.fifoNum); end
            bus.rdAddr = 11'(k);
            tick();
            e0 = 24'(10000 + (k - 1) * 1000 + k);
            e1 = 24'(10000 + k * 1000 + k);
            n_vec++; if (bus.rdData0 !== e0 || bus.rdData1 !== e1) begin n_err++; $display("FAIL wrap_rd%0d: got %0d/%0d want %0d/%0d", k, bus.rdData0, bus.rdData1, e0, e1); end
            pulse_rdjmp();
        end
    endtask

    task automatic test_reset_midline();
        write_line(30000, 16); pulse_jmp();
        write_line(31000, 16); pulse_jmp();
        n_vec++; if (bus.fifoNum !== 3'd3) begin n_err++; $display("FAIL pre_rst_fifoNum: got %0d want 3", bus.fifoNum); end
        bus.rdAddr = 11'd2;
        write_line(32000, 5);
        #3 rst = 1'b0;
        #1;
        n_vec++; if (bus.fifoNum !== 3'd0 || bus.rdValid !== 1'b0) begin n_err++; $display("FAIL rst_state: got %0d/%b want 0/0", bus.fifoNum, bus.rdValid); end
        n_vec++; if (bus.rdData0 !== 24'd0 || bus.rdData1 !== 24'd0) begin n_err++; $display("FAIL rst_data: got %0d/%0d want 0/0", bus.rdData0, bus.rdData1); end
        @(negedge clk);
        rst = 1'b1;
        write_line(20000, 16); pulse_jmp();
        write_line(21000, 16); pulse_jmp();
        bus.rdAddr = 11'd3;
        tick();
        n_vec++; if (bus.rdData0 !== 24'd20003 || bus.rdData1 !== 24'd21003) begin n_err++; $display("FAIL post_rst_rd: got %0d/%0d want 20003/21003", bus.rdData0, bus.rdData1); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_fill();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
